// File: rtl/div_pkg.sv
// ============================================================================
// Module : div_pkg
// Brief  : Shared constants and terminal-value helper for the frequency divider
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package div_pkg;

    localparam logic MODE_UP = 1'b1;
    localparam logic MODE_DN = 1'b0;

    // Returned at the widest supported counter width; callers zero-extend.
    function automatic logic [63:0] term_val(input logic mode, input int width);
        if (mode == MODE_UP) begin
            term_val = ~(~64'd0 << width);
        end else begin
            term_val = 64'd0;
        end
    endfunction

endpackage

`default_nettype wire

// File: rtl/prog_freq_divider_if.sv
// ============================================================================
// Module : prog_freq_divider_if
// Brief  : Control/status bundle of the programmable frequency divider
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

interface prog_freq_divider_if #(
    parameter int WIDTH = 8
);
    logic             en;
    logic             mode;
    logic [WIDTH-1:0] load_val;
    logic             load_stb;
    logic             force_load;
    logic [WIDTH-1:0] cnt_out;
    logic             tc;
    logic             sq_out;

    modport master (
        output en, mode, load_val, load_stb, force_load,
        input  cnt_out, tc, sq_out
    );

    modport slave (
        input  en, mode, load_val, load_stb, force_load,
        output cnt_out, tc, sq_out
    );
endinterface

`default_nettype wire

// File: rtl/div_shadow_reg.sv
// ============================================================================
// Module : div_shadow_reg
// Brief  : Shadow reload value/mode; force_load overrides a concurrent strobe
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module div_shadow_reg #(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_LOAD = '0,
    parameter logic             RESET_MODE = 1'b1
) (
    input  wire logic             clk,
    input  wire logic             rst,
    input  wire logic             load_stb_i,
    input  wire logic             force_load_i,
    input  wire logic [WIDTH-1:0] load_val_i,
    input  wire logic             mode_i,
    output logic      [WIDTH-1:0] sh_load_o,
    output logic                  sh_mode_o
);

    logic [WIDTH-1:0] sh_load_q, sh_load_d;
    logic             sh_mode_q, sh_mode_d;

    always_comb begin
        sh_load_d = sh_load_q;
        sh_mode_d = sh_mode_q;
        if (force_load_i || load_stb_i) begin
            sh_load_d = load_val_i;
            sh_mode_d = mode_i;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            sh_load_q <= RESET_LOAD;
            sh_mode_q <= RESET_MODE;
        end else begin
            sh_load_q <= sh_load_d;
            sh_mode_q <= sh_mode_d;
        end
    end

    assign sh_load_o = sh_load_q;
    assign sh_mode_o = sh_mode_q;

endmodule

`default_nettype wire

// File: rtl/prog_freq_divider.sv
// ============================================================================
// Module : prog_freq_divider
// Brief  : Programmable up/down divider with tc pulse and 50% square wave
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module prog_freq_divider
    import div_pkg::*;
#(
    parameter int               WIDTH      = 8,
    parameter logic [WIDTH-1:0] RESET_LOAD = '0,
    parameter logic             RESET_MODE = 1'b1
) (
    input  wire logic         clk,
    input  wire logic         rst,
    prog_freq_divider_if.slave bus
);

    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic             act_mode_q, act_mode_d;
    logic             sq_q, sq_d;
    logic [WIDTH-1:0] sh_load;
    logic             sh_mode;
    logic             at_term;

    div_shadow_reg #(
        .WIDTH      (WIDTH),
        .RESET_LOAD (RESET_LOAD),
        .RESET_MODE (RESET_MODE)
    ) u_shadow (
        .clk          (clk),
        .rst          (rst),
        .load_stb_i   (bus.load_stb),
        .force_load_i (bus.force_load),
        .load_val_i   (bus.load_val),
        .mode_i       (bus.mode),
        .sh_load_o    (sh_load),
        .sh_mode_o    (sh_mode)
    );

    assign at_term = (64'(cnt_q) == term_val(act_mode_q, WIDTH));

    // Reloading at the terminal value pre-empts the wrap, so the count never rolls over.
    always_comb begin
        cnt_d      = cnt_q;
        act_mode_d = act_mode_q;
        sq_d       = sq_q;
        if (bus.force_load) begin
            cnt_d      = bus.load_val;
            act_mode_d = bus.mode;
        end else if (bus.en) begin
            if (at_term) begin
                cnt_d      = sh_load;
                act_mode_d = sh_mode;
                sq_d       = ~sq_q;
            end else if (act_mode_q == MODE_UP) begin
                cnt_d = cnt_q + 1'b1;
            end else begin
                cnt_d = cnt_q - 1'b1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt_q      <= RESET_LOAD;
            act_mode_q <= RESET_MODE;
            sq_q       <= 1'b0;
        end else begin
            cnt_q      <= cnt_d;
            act_mode_q <= act_mode_d;
            sq_q       <= sq_d;
        end
    end

    assign bus.cnt_out = cnt_q;
    assign bus.tc      = bus.en & at_term;
    assign bus.sq_out  = sq_q;

endmodule

`default_nettype wire
